sim_pattern_gen: RTL and testbench
==================================

Name: sim_pattern_gen

Overview:
- Parametrised stimulus source for DDR FIFO bring-up and simulation.
- Produces a stream of DATA_W-bit words using one of four patterns.
- Output uses a valid/ready handshake so the FIFO write side can apply backpressure.
- Supports bursts of programmable length separated by programmable idle gaps, with a last-beat marker and a beat counter for scoreboarding.

Parameters:
- DATA_W, 32, data word width (>=8).
- LEN_W, 16, width of BurstLen and BeatCount.
- GAP_W, 8, width of GapLen.
- LFSR_POLY, 32'h80200003, Galois LFSR feedback taps (low DATA_W bits used).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- En  in  1  run enable
- Mode  in  2  0=increment, 1=decrement, 2=walking-one, 3=LFSR
- Seed  in  DATA_W  first word of a run (LFSR: 0 is replaced by 1)
- BurstLen  in  LEN_W  beats per burst; 0 = continuous, no bursts
- GapLen  in  GAP_W  idle cycles between bursts; 0 = back-to-back
- DataOut  out  DATA_W  current word
- DataOutValid  out  1  word valid
- DataOutReady  in  1  consumer accepts word
- BurstLast  out  1  current word is the last beat of a burst
- BeatCount  out  LEN_W  beat index of DataOut within its burst (0-based)
- Busy  out  1  FSM not in IDLE

Behaviour:
- Transfer = DataOutValid & DataOutReady on a rising edge of clk.
- Reset (rst=1 at an edge, overrides all other inputs):
  - DataOut=0, DataOutValid=0, BurstLast=0, BeatCount=0, Busy=0; FSM -> IDLE.
  - Reset mid-burst abandons the burst with no final beat.
- FSM states IDLE, RUN, GAP.
- IDLE:
  - Outputs as after reset.
  - On an edge with En=1: latch Mode, BurstLen, GapLen; DataOut<=Seed (Mode 3 and Seed=0 -> 1); DataOutValid<=1; BeatCount<=0; go to RUN.
  - First valid word appears 1 cycle after En is sampled high.
  - Config inputs are ignored outside IDLE.
- RUN:
  - DataOutValid=1. While not ready, DataOut, BeatCount and BurstLast hold stable (no pattern advance, no drop of valid).
  - On each transfer, the next word is:
    - Mode 0: DataOut+1, wrapping modulo 2^DATA_W (all-ones -> 0).
    - Mode 1: DataOut-1, wrapping (0 -> all-ones).
    - Mode 2: rotate left by 1 (MSB -> bit0).
    - Mode 3: Galois step. If bit0=1, (DataOut>>1)^LFSR_POLY, else DataOut>>1.
  - Pattern state persists across bursts and gaps; it restarts from Seed only via IDLE.
  - BurstLast = (BurstLen!=0) & (BeatCount==BurstLen-1). Combinational from registered state, stable while stalled.
  - Transfer with BurstLast=1:
    - GapLen=0: next word continues immediately, BeatCount<=0, stays RUN.
    - GapLen>0: DataOutValid<=0, go to GAP for exactly GapLen cycles.
  - Transfer with BurstLast=0: BeatCount<=BeatCount+1. For BurstLen=0, BeatCount wraps freely modulo 2^LEN_W.
  - BurstLen=1: every beat is last.
- GAP:
  - DataOutValid=0; DataOut holds the next word; BeatCount=0.
  - After GapLen cycles, return to RUN with valid high.
- En deassert:
  - RUN with valid high: hold until the pending word transfers, then go to IDLE. Valid never drops without a transfer.
  - GAP: go to IDLE at the next edge.
  - If the pending word also has BurstLast=1, go to IDLE, not GAP.
  - En reasserted in IDLE restarts from Seed.
- Busy=1 in RUN and GAP.
- Throughput with DataOutReady tied high and GapLen=0: one word per cycle, no bubbles, including across burst boundaries.

Test Plan:
- Reset, Mode=0, Seed=0, BurstLen=0, En=1, ready=1 for 10 cycles -> DataOut 0..9 on consecutive cycles, BurstLast never 1; all outputs 0 while rst=1.
- Mode=0, Seed=32'hFFFFFFFE, ready toggled 1,0,0,1,1 -> accepted sequence FFFFFFFE, FFFFFFFF, 00000000; DataOut/valid stable through the stall cycles.
- Mode=0, Seed=100, BurstLen=4, GapLen=3, ready=1 -> beats 100-103 with BurstLast on 103, BeatCount 0-3; valid low exactly 3 cycles; then 104-107.
- Mode=3, Seed=0, DATA_W=32 -> first word 1, second word 80200003 (default poly); Mode=2, Seed=32'h80000000 -> second word 00000001.
- En dropped while valid=1 and ready=0 for 5 cycles -> valid stays high 5 cycles; transfers once on ready; then valid=0, Busy=0 next cycle.
- rst asserted mid-burst at beat 2 of BurstLen=8 -> next cycle all outputs 0; En=1 restarts at Seed with BeatCount=0.

Source files
------------

// File: rtl/sim_pattern_gen.sv
// Pattern stimulus source: increment/decrement/walking-one/LFSR words on a valid/ready stream,
// optionally chopped into bursts separated by idle gaps.
module sim_pattern_gen #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned GAP_W     = 8,
   parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              En,
   input  logic [1:0]        Mode,
   input  logic [DATA_W-1:0] Seed,
   input  logic [LEN_W-1:0]  BurstLen,
   input  logic [GAP_W-1:0]  GapLen,
   output logic [DATA_W-1:0] DataOut,
   output logic              DataOutValid,
   input  logic              DataOutReady,
   output logic              BurstLast,
   output logic [LEN_W-1:0]  BeatCount,
   output logic              Busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

   localparam logic [DATA_W-1:0] Poly = DATA_W'(LFSR_POLY);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [1:0]        mode_q, mode_d;
   logic [LEN_W-1:0]  blen_q, blen_d;
   logic [GAP_W-1:0]  glen_q, glen_d;
   logic [GAP_W-1:0]  gcnt_q, gcnt_d;
   logic [DATA_W-1:0] next_word;
   logic              burst_last;

   always_comb begin
      next_word = data_q;
      case (mode_q)
         2'd0:    next_word = data_q + DATA_W'(1);
         2'd1:    next_word = data_q - DATA_W'(1);
         2'd2:    next_word = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
         default: next_word = data_q[0] ? ((data_q >> 1) ^ Poly) : (data_q >> 1);
      endcase
   end

   assign burst_last = (state_q == StRun) && (blen_q != '0) && (beat_q == blen_q - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      beat_d  = beat_q;
      mode_d  = mode_q;
      blen_d  = blen_q;
      glen_d  = glen_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         StIdle: begin
            if (En) begin
               mode_d  = Mode;
               blen_d  = BurstLen;
               glen_d  = GapLen;
               // An all-zero LFSR state would lock up, so seed it with 1 instead
               data_d  = (Mode == 2'd3 && Seed == '0) ? DATA_W'(1) : Seed;
               beat_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (DataOutReady) begin
               if (!En) begin
                  state_d = StIdle;
                  data_d  = '0;
                  beat_d  = '0;
               end else begin
                  data_d = next_word;
                  if (burst_last) begin
                     beat_d = '0;
                     if (glen_q != '0) begin
                        state_d = StGap;
                        gcnt_d  = glen_q;
                     end
                  end else begin
                     beat_d = beat_q + LEN_W'(1);
                  end
               end
            end
         end
         StGap: begin
            if (!En) begin
               state_d = StIdle;
               data_d  = '0;
            end else if (gcnt_q <= GAP_W'(1)) begin
               state_d = StRun;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            data_d  = '0;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         beat_q  <= '0;
         mode_q  <= '0;
         blen_q  <= '0;
         glen_q  <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
         mode_q  <= mode_d;
         blen_q  <= blen_d;
         glen_q  <= glen_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign DataOut      = data_q;
   assign DataOutValid = (state_q == StRun);
   assign BurstLast    = burst_last;
   assign BeatCount    = beat_q;
   assign Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sim_pattern_gen.sv
// Scoreboard bench for sim_pattern_gen: runs are predicted from the pattern rules into a queue,
// and a negedge monitor checks every transfer, stall, gap length and return to idle.
module tb_sim_pattern_gen;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 16;
   localparam int unsigned GW = 8;
   localparam logic [31:0] POLY = 32'h80200003;

   logic          clk = 1'b0;
   logic          rst;
   logic          En;
   logic [1:0]    Mode;
   logic [DW-1:0] Seed;
   logic [LW-1:0] BurstLen;
   logic [GW-1:0] GapLen;
   logic [DW-1:0] DataOut;
   logic          DataOutValid;
   logic          DataOutReady;
   logic          BurstLast;
   logic [LW-1:0] BeatCount;
   logic          Busy;

   sim_pattern_gen #(
      .DATA_W(DW), .LEN_W(LW), .GAP_W(GW), .LFSR_POLY(POLY)
   ) dut (
      .clk(clk), .rst(rst), .En(En), .Mode(Mode), .Seed(Seed), .BurstLen(BurstLen),
      .GapLen(GapLen), .DataOut(DataOut), .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady), .BurstLast(BurstLast), .BeatCount(BeatCount), .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [15:0] beat;
      logic        last;
      logic        fin;
      int          gap;
   } exp_t;

   exp_t sbq[$];
   bit   ready_pat[$];
   int   tests = 0;
   int   fails = 0;
   int   xfers = 0;
   int   run_base = 0;
   int   ready_pct = 100;
   bit   mon_off = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Word k of a run, straight from the pattern definitions
   function automatic logic [31:0] model_word(input int mode, input logic [31:0] seed, input int k);
      logic [31:0] x;
      int r;
      case (mode)
         0: return seed + 32'(k);
         1: return seed - 32'(k);
         2: begin
            r = k % 32;
            x = (seed << r) | (seed >> (32 - r));
            return x;
         end
         default: begin
            x = (seed == 32'd0) ? 32'd1 : seed;
            for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
            return x;
         end
      endcase
   endfunction

   // Ready driver: a queued pattern first, otherwise random with ready_pct probability
   initial begin
      DataOutReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_pat.size() > 0) DataOutReady = ready_pat.pop_front();
         else DataOutReady = ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: outputs are stable at negedge, and ready does not change before the next posedge
   initial begin
      bit          stall, gtrack, exp_idle;
      logic [31:0] sd;
      logic [15:0] sb;
      logic        sl;
      int          gcount, gexp;
      exp_t        e;
      stall = 0; gtrack = 0; exp_idle = 0; gcount = 0; gexp = 0;
      forever begin
         @(negedge clk);
         if (mon_off || rst) begin
            stall = 0; gtrack = 0; exp_idle = 0;
            continue;
         end
         if (exp_idle) begin
            chk("idle_valid", DataOutValid, 0);
            chk("idle_busy", Busy, 0);
            chk("idle_data", DataOut, 0);
            exp_idle = 0;
         end
         if (gtrack) begin
            if (!DataOutValid) begin
               gcount++;
               chk("gap_beat", BeatCount, 0);
               chk("gap_busy", Busy, 1);
            end else begin
               chk("gap_len", gcount, gexp);
               gtrack = 0;
            end
         end
         if (stall) begin
            chk("stall_valid", DataOutValid, 1);
            chk("stall_data", DataOut, sd);
            chk("stall_beat", BeatCount, sb);
            chk("stall_last", BurstLast, sl);
            stall = 0;
         end
         if (DataOutValid && DataOutReady) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_xfer: got data %0h, expected no transfer", DataOut);
            end else begin
               e = sbq.pop_front();
               chk("data", DataOut, e.data);
               chk("beat", BeatCount, e.beat);
               chk("last", BurstLast, e.last);
               chk("busy", Busy, 1);
               if (e.fin) exp_idle = 1;
               else if (e.last) begin
                  gtrack = 1; gcount = 0; gexp = e.gap;
               end
            end
            xfers++;
         end else if (DataOutValid) begin
            stall = 1; sd = DataOut; sb = BeatCount; sl = BurstLast;
         end
      end
   end

   task automatic do_reset(input int cycles);
      mon_off = 1'b1;
      rst = 1'b1;
      En = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #2;
         chk("rst_data", DataOut, 0);
         chk("rst_valid", DataOutValid, 0);
         chk("rst_last", BurstLast, 0);
         chk("rst_beat", BeatCount, 0);
         chk("rst_busy", Busy, 0);
      end
      sbq.delete();
      rst = 1'b0;
      mon_off = 1'b0;
   endtask

   task automatic start_run(input int mode, input logic [31:0] seed, input int bl, input int gl,
                            input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.data = model_word(mode, seed, k);
         e.beat = (bl == 0) ? 16'(k) : 16'(k % bl);
         e.last = (bl != 0) && ((k % bl) == bl - 1);
         e.fin  = (k == n - 1);
         e.gap  = gl;
         sbq.push_back(e);
      end
      run_base = xfers;
      Mode = 2'(mode);
      Seed = seed;
      BurstLen = 16'(bl);
      GapLen = 8'(gl);
      En = 1'b1;
   endtask

   // Keep En high until word n is pending, then drop it so that word ends the run
   task automatic finish_run(input int n);
      int budget;
      budget = 3000;
      while (!((xfers - run_base) == n - 1 && DataOutValid === 1'b1) && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      En = 1'b0;
      while ((xfers - run_base) < n && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      chk("run_xfers", xfers - run_base, n);
      if (budget == 0) do_reset(1);
      repeat (2) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget, mode, bl, gl, n;
      logic [31:0] seed;
      rst = 1'b1; En = 1'b0; Mode = '0; Seed = '0; BurstLen = '0; GapLen = '0;
      do_reset(3);

      ready_pct = 100;
      start_run(0, 32'd0, 0, 0, 10);
      finish_run(10);

      ready_pct = 0;
      start_run(0, 32'hFFFFFFFE, 0, 0, 3);
      @(posedge clk);
      #2;
      ready_pat.push_back(1); ready_pat.push_back(0); ready_pat.push_back(0);
      ready_pat.push_back(1); ready_pat.push_back(1);
      ready_pct = 100;
      finish_run(3);

      start_run(0, 32'd100, 4, 3, 8);
      finish_run(8);

      start_run(3, 32'd0, 0, 0, 2);
      finish_run(2);
      start_run(2, 32'h80000000, 0, 0, 2);
      finish_run(2);

      // En dropped while the first word is stalled
      ready_pct = 0;
      start_run(0, 32'h55, 0, 0, 1);
      @(posedge clk);
      #2;
      for (int i = 0; i < 5; i++) ready_pat.push_back(0);
      ready_pct = 100;
      finish_run(1);

      // Reset with beat 2 of an 8-beat burst pending, then restart from Seed
      start_run(0, 32'h1000, 8, 2, 8);
      budget = 100;
      while ((xfers - run_base) < 2 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      chk("midburst_beat", BeatCount, 2);
      do_reset(1);
      start_run(0, 32'h1000, 8, 2, 3);
      finish_run(3);

      for (int r = 0; r < 30; r++) begin
         mode = int'($urandom_range(3));
         case ($urandom_range(2))
            0: seed = 32'd0;
            1: seed = 32'hFFFFFFF0 + 32'($urandom_range(15));
            default: seed = $urandom;
         endcase
         bl = int'($urandom_range(5));
         gl = int'($urandom_range(3));
         n = int'($urandom_range(25, 1));
         case ($urandom_range(2))
            0: ready_pct = 100;
            1: ready_pct = 70;
            default: ready_pct = 40;
         endcase
         start_run(mode, seed, bl, gl, n);
         finish_run(n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
